// File: rtl/demux4_buf.sv
// demux4_buf: 1-to-4 demultiplexer with a small FIFO on each output port.
// Define DEMUX4_BUF_BYPASS_EN to let a word cut through an empty queue in the same cycle.
module demux4_buf #(
  parameter int width = 16,
  parameter int depth = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_sel,
  input  logic [width-1:0] in_data,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [width-1:0] out_data0,
  output logic [width-1:0] out_data1,
  output logic [width-1:0] out_data2,
  output logic [width-1:0] out_data3
);

  localparam int AW = (depth > 1) ? $clog2(depth) : 1;

  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;

  localparam cnt_t FULL = cnt_t'(depth);

  logic [3:0]       full;
  logic [width-1:0] head [4];

  // Ready depends only on registered fullness, never on this cycle's pops.
  assign in_ready = !rst && !full[in_sel];

  assign out_data0 = head[0];
  assign out_data1 = head[1];
  assign out_data2 = head[2];
  assign out_data3 = head[3];

  for (genvar g = 0; g < 4; g++) begin : g_port
    logic [width-1:0] mem [depth];
    ptr_t             rptr;
    ptr_t             wptr;
    cnt_t             cnt;
    logic             sel;
    logic             stored;
    logic             push;
    logic             pop;
    logic             byp;

    assign sel    = in_valid && (in_sel == 2'(g));
    assign stored = (cnt != '0);
    assign full[g] = (cnt == FULL);

`ifdef DEMUX4_BUF_BYPASS_EN
    logic offer;
    assign offer        = !rst && sel && !stored;
    assign byp          = offer && out_ready[g];
    assign out_valid[g] = stored || offer;
    assign head[g]      = offer ? in_data : mem[rptr];
`else
    assign byp          = 1'b0;
    assign out_valid[g] = stored;
    assign head[g]      = mem[rptr];
`endif

    assign push = sel && in_ready && !byp;
    assign pop  = stored && out_ready[g];

    always_ff @(posedge clk) begin
      if (rst) begin
        rptr <= '0;
        wptr <= '0;
        cnt  <= '0;
        for (int e = 0; e < depth; e++) begin
          mem[e] <= '0;
        end
      end else begin
        if (push) begin
          mem[wptr] <= in_data;
          wptr      <= wptr + ptr_t'(1);
        end
        if (pop) begin
          rptr <= rptr + ptr_t'(1);
        end
        if (push && !pop) begin
          cnt <= cnt + cnt_t'(1);
        end else if (pop && !push) begin
          cnt <= cnt - cnt_t'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_demux4_buf.sv
// tb_demux4_buf: scoreboard bench for demux4_buf.
// Model is four plain queues; the monitor pops and compares on every handshake.
module tb_demux4_buf;

  localparam int W = 16;
  localparam int D = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [1:0]   in_sel = '0;
  logic [W-1:0] in_data = '0;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready = '0;
  logic [W-1:0] od0, od1, od2, od3;

  int checks = 0;
  int passed = 0;

  logic [W-1:0] sbq [4][$];

  always #5 clk = ~clk;

  demux4_buf #(.width(W), .depth(D)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_sel(in_sel),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data0(od0),
    .out_data1(od1),
    .out_data2(od2),
    .out_data3(od3)
  );

  function automatic logic [W-1:0] odat(input int i);
    case (i)
      0: return od0;
      1: return od1;
      2: return od2;
      default: return od3;
    endcase
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // One cycle: drive at +2, check ready at +4, update model at +8.
  task automatic cycle(input logic v, input logic r, input logic [1:0] s,
                       input logic [W-1:0] d, input logic [3:0] ordy,
                       output bit acc);
    @(posedge clk);
    #2;
    rst = r;
    in_valid = v;
    in_sel = s;
    in_data = d;
    out_ready = ordy;
    #2;
    chk("in_ready", W'(in_ready), W'(!r && sbq[s].size() < D));
    acc = v && !r && (sbq[s].size() < D);
    #4;
    if (r) begin
      for (int i = 0; i < 4; i++) sbq[i].delete();
    end else if (acc) begin
`ifdef DEMUX4_BUF_BYPASS_EN
      if (!(sbq[s].size() == 0 && ordy[s])) sbq[s].push_back(d);
`else
      sbq[s].push_back(d);
`endif
    end
  endtask

  // Monitor at +6: out_valid and head data against the model.
  initial begin
    forever begin
      @(posedge clk);
      #6;
      for (int i = 0; i < 4; i++) begin
        logic         ev;
        logic [W-1:0] ed;
        ev = sbq[i].size() != 0;
        ed = ev ? sbq[i][0] : '0;
`ifdef DEMUX4_BUF_BYPASS_EN
        if (!rst && in_valid && in_sel == 2'(i) && sbq[i].size() == 0) begin
          ev = 1'b1;
          ed = in_data;
        end
`endif
        chk($sformatf("out_valid%0d", i), W'(out_valid[i]), W'(ev));
        if (ev) begin
          chk($sformatf("out_data%0d", i), odat(i), ed);
          if (out_ready[i] && sbq[i].size() != 0) void'(sbq[i].pop_front());
        end
      end
    end
  end

  initial begin
    bit acc;
    logic [W-1:0] na, nb;
    logic [1:0] s;
    cycle(0, 1, 0, '0, '0, acc);
    cycle(0, 0, 0, '0, '0, acc);
    for (int s2 = 0; s2 < 4; s2++) begin
      in_sel = 2'(s2);
      #1;
      chk("rst_ready", W'(in_ready), W'(1));
      chk("rst_data", odat(s2), '0);
    end

    cycle(1, 0, 2, 16'h1111, 4'b0000, acc);
    cycle(1, 0, 2, 16'h2222, 4'b0000, acc);
    cycle(1, 0, 2, 16'hAAAA, 4'b0000, acc);
    chk("full_reject", W'(acc), W'(0));
    cycle(0, 0, 0, '0, 4'b0000, acc);
    chk("hold2", od2, 16'h1111);
    cycle(1, 0, 2, 16'h3333, 4'b0100, acc);
    cycle(1, 0, 2, 16'h3333, 4'b0100, acc);
    chk("push_after_pop", W'(acc), W'(1));
    cycle(0, 0, 0, '0, 4'b0100, acc);
    cycle(0, 0, 0, '0, 4'b0100, acc);

    cycle(1, 0, 1, 16'h0BEE, 4'b0000, acc);
    cycle(1, 1, 1, 16'h0BAD, 4'b0000, acc);
    cycle(0, 0, 0, '0, 4'b0010, acc);
    chk("rst_flush", W'(out_valid), '0);

    cycle(1, 0, 0, 16'h5A5A, 4'b0001, acc);
    cycle(0, 0, 0, '0, 4'b0001, acc);
    cycle(0, 0, 0, '0, 4'b0001, acc);

    na = 16'h00A0;
    nb = 16'h00B0;
    for (int n = 0; n < 200; n++) begin
      s = ($urandom_range(0, 1) != 0) ? 2'd3 : 2'd0;
      cycle(1'($urandom_range(0, 3) != 0), 0, s, (s == 0) ? na : nb,
            {1'($urandom), 2'b00, 1'($urandom)}, acc);
      if (acc && s == 0) na++;
      if (acc && s == 3) nb++;
    end

    for (int n = 0; n < 400; n++) begin
      cycle(1'($urandom), 1'($urandom_range(0, 60) == 0),
            2'($urandom), W'($urandom), 4'($urandom), acc);
    end

    for (int n = 0; n < 2 * D + 2; n++) cycle(0, 0, 0, '0, 4'b1111, acc);
    for (int i = 0; i < 4; i++) chk("drained", W'(sbq[i].size()), '0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/demux4_buf.md
DEMUX4_BUF -- requirements
Module: demux4_buf

Interface
REQ-001 Parameter width, default 16, payload bit width; legal 1..128.
REQ-002 Parameter depth, default 2, entries per output queue; legal values 2, 4, 8, 16.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  source offers a word this cycle.
REQ-006 in_ready  output  1  block accepts the offered word this cycle.
REQ-007 in_sel  input  2  destination port index 0..3 for the offered word.
REQ-008 in_data  input  width  offered payload.
REQ-009 out_valid  output  4  bit i: port i presents a word.
REQ-010 out_ready  input  4  bit i: sink i takes the presented word.
REQ-011 out_data0, out_data1, out_data2, out_data3  output  width each  payload presented on port 0..3.

Function
REQ-012 Each port i SHALL own an independent FIFO queue of depth entries with a read pointer, a write pointer and an occupancy count (0..depth).
REQ-013 in_ready SHALL be 1 iff the queue selected by in_sel is not full (count < depth), decoded combinationally from in_sel and registered counts only.
REQ-014 A push SHALL occur on an edge where in_valid && in_ready; the word is written to queue[in_sel] at its write pointer.
REQ-015 out_valid[i] SHALL be 1 iff count_i != 0 (bypass excepted, REQ-031); out_dataN SHALL show the head entry of queue N.
REQ-016 A pop of port i SHALL occur on an edge where out_valid[i] && out_ready[i]; read pointer advances and the entry is discarded.
REQ-017 Pointers SHALL wrap from depth-1 to 0; counts SHALL never exceed depth or go below 0.
REQ-018 Push and pop on the same port in the same cycle SHALL leave count unchanged and preserve FIFO order.
REQ-019 Pops on any subset of ports SHALL proceed in the same cycle, independently of the push.
REQ-020 At most one push per cycle; words to the same port SHALL be delivered in acceptance order.
REQ-021 A full port SHALL stall only input words addressed to it; in_sel values for non-full ports SHALL be accepted.
REQ-022 When in_ready is 0, in_data and in_sel SHALL be ignored; the block SHALL not require them to be held stable.
REQ-023 out_valid[i], once asserted, SHALL stay asserted with stable out_data until the pop, except by reset.
REQ-024 Latency without bypass: a word pushed on edge k SHALL appear on its port after edge k (visible in cycle k+1).
REQ-025 Throughput: one word per cycle sustained when the selected sink holds out_ready high.

Reset
REQ-026 When rst is 1 at an edge, all counts and pointers SHALL be 0 and all queue storage SHALL be 0.
REQ-027 After reset: out_valid = 4'b0000, out_data0..3 = 0, in_ready = 1 for every in_sel.
REQ-028 Reset SHALL take priority over a simultaneous push or pop; words in flight or queued are discarded.
REQ-029 During rst = 1, in_ready SHALL be driven 0 so no handshake is claimed.

Configuration
REQ-030 Macro DEMUX4_BUF_BYPASS_EN SHALL select same-cycle cut-through.
REQ-031 With DEMUX4_BUF_BYPASS_EN defined: when count_i == 0 and in_valid && in_sel == i, out_valid[i] SHALL be 1 and out_data_i = in_data combinationally; if out_ready[i] is also 1, the word SHALL be delivered without being written and count_i stays 0; otherwise the word is pushed normally.
REQ-032 Without the macro: no combinational path from in_valid/in_data to out_valid/out_data; latency per REQ-024.

Verification
REQ-033 Reset then idle -> out_valid = 0000, all out_data = 0, in_ready = 1 for in_sel 0..3.
REQ-034 width=16, depth=2; push 0x1111, 0x2222 to port 2 with out_ready=0000 -> count full, in_ready = 0 for in_sel=2, = 1 for in_sel=0; out_data2 = 0x1111 held.
REQ-035 Port 2 full, out_ready[2]=1 and push 0x3333 to port 2 same cycle -> in_ready = 0 that cycle (registered full); next cycle push accepted; delivery order 0x1111, 0x2222, 0x3333.
REQ-036 Streams 0xA0.. to port 0 and 0xB0.. to port 3 interleaved, out_ready=1001 random toggling -> each port receives its sequence in order, no loss or duplication.
REQ-037 Port 1 holds one word, rst pulsed for one cycle during a push -> out_valid = 0000 after edge; pushed word not delivered.
REQ-038 Bypass build: queue 0 empty, in_valid=1, in_sel=0, in_data=0x5A5A, out_ready[0]=1 -> out_valid[0]=1 same cycle, out_data0 = 0x5A5A, count_0 remains 0; non-bypass build -> word appears one cycle later.
